// File: rtl/fc_seq_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer.
// Holds the FSM encoding, the memory port widths and the packed per-layer base lookup.
package fc_seq_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int MAX_LAYERS = 8;
  localparam int VEC_W      = ADDR_W * MAX_LAYERS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RUN   = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  // Pick the 16-bit field for layer k out of a vector zero-extended to MAX_LAYERS slots.
  function automatic logic [ADDR_W-1:0] base_of(input logic [VEC_W-1:0] vec,
                                                input logic [2:0]       k);
    return vec[{k, 4'b0000} +: ADDR_W];
  endfunction

endpackage

// File: rtl/fc_mem_mux.sv
// Registered shared-memory port mux: selects the active engine's request and adds
// that layer's read or write base (16-bit, wrapping).
module fc_mem_mux
  import fc_seq_pkg::*;
#(
  parameter int                           NUM_LAYERS = 3,
  parameter logic [ADDR_W*NUM_LAYERS-1:0] RD_BASE    = {16'd0, 16'd200, 16'd400},
  parameter logic [ADDR_W*NUM_LAYERS-1:0] WR_BASE    = {16'd200, 16'd400, 16'd600}
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         active,
  input  logic [2:0]                   sel,
  input  logic [ADDR_W*NUM_LAYERS-1:0] eng_addr,
  input  logic [NUM_LAYERS-1:0]        eng_we,
  input  logic [DATA_W*NUM_LAYERS-1:0] eng_out,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_we,
  output logic [DATA_W-1:0]            mem_wdata
);

  localparam logic [VEC_W-1:0] RD_EXT = VEC_W'(RD_BASE);
  localparam logic [VEC_W-1:0] WR_EXT = VEC_W'(WR_BASE);

  logic [VEC_W-1:0]      addr_ext;
  logic [VEC_W-1:0]      out_ext;
  logic [MAX_LAYERS-1:0] we_ext;
  logic [ADDR_W-1:0]     sel_addr;
  logic [ADDR_W-1:0]     sel_out;
  logic [ADDR_W-1:0]     rd_base;
  logic [ADDR_W-1:0]     wr_base;

  assign addr_ext = VEC_W'(eng_addr);
  assign out_ext  = VEC_W'(eng_out);
  assign we_ext   = MAX_LAYERS'(eng_we);
  assign sel_addr = base_of(addr_ext, sel);
  assign sel_out  = base_of(out_ext, sel);
  assign rd_base  = base_of(RD_EXT, sel);
  assign wr_base  = base_of(WR_EXT, sel);

  // Engine output addresses are 1-based, so writes land one below base+addr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (!active) begin
      mem_addr <= '0;
      mem_we   <= 1'b0;
    end else if (we_ext[sel]) begin
      mem_addr  <= wr_base + sel_addr - ADDR_W'(1);
      mem_we    <= 1'b1;
      mem_wdata <= sel_out;
    end else begin
      mem_addr <= rd_base + sel_addr;
      mem_we   <= 1'b0;
    end
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequences NUM_LAYERS fully-connected engines one at a time over a shared memory port,
// advancing on each engine's layer_end and flagging stale status or per-layer timeout.
module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int                           NUM_LAYERS = 3,
  parameter logic [ADDR_W*NUM_LAYERS-1:0] RD_BASE    = {16'd0, 16'd200, 16'd400},
  parameter logic [ADDR_W*NUM_LAYERS-1:0] WR_BASE    = {16'd200, 16'd400, 16'd600},
  parameter logic [19:0]                  TIMEOUT    = 20'd65535
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [ADDR_W*NUM_LAYERS-1:0] eng_addr,
  input  logic [NUM_LAYERS-1:0]        eng_we,
  input  logic [DATA_W*NUM_LAYERS-1:0] eng_out,
  input  logic [NUM_LAYERS-1:0]        eng_end,
  output logic [NUM_LAYERS-1:0]        eng_en,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_we,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [2:0]                   cur_layer,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam logic [NUM_LAYERS-1:0] EN_ONE     = NUM_LAYERS'(1);
  localparam logic [2:0]            LAST_LAYER = 3'(NUM_LAYERS - 1);

  state_t                state;
  logic [19:0]           timer;
  logic                  end_prev;
  logic [MAX_LAYERS-1:0] end_ext;
  logic                  cur_end;

  assign end_ext = MAX_LAYERS'(eng_end);
  assign cur_end = end_ext[cur_layer];

  // end_prev holds last cycle's sample of the active engine's layer_end so only a 0->1 edge advances.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      eng_en    <= '0;
      cur_layer <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      timer     <= '0;
      end_prev  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state     <= ST_CHECK;
            cur_layer <= 3'd0;
            done      <= 1'b0;
            error     <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (cur_end) begin
            state <= ST_ERROR;
            error <= 1'b1;
          end else begin
            state    <= ST_RUN;
            eng_en   <= EN_ONE << cur_layer;
            busy     <= 1'b1;
            timer    <= '0;
            end_prev <= 1'b0;
          end
        end
        ST_RUN: begin
          timer    <= timer + 20'd1;
          end_prev <= cur_end;
          if (cur_end && !end_prev) begin
            state  <= ST_GAP;
            eng_en <= '0;
          end else if (timer == TIMEOUT - 20'd1) begin
            state  <= ST_ERROR;
            eng_en <= '0;
            busy   <= 1'b0;
            error  <= 1'b1;
          end
        end
        ST_GAP: begin
          busy <= 1'b0;
          if (cur_layer == LAST_LAYER) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state     <= ST_CHECK;
            cur_layer <= cur_layer + 3'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          eng_en <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  fc_mem_mux #(
    .NUM_LAYERS(NUM_LAYERS),
    .RD_BASE   (RD_BASE),
    .WR_BASE   (WR_BASE)
  ) u_mem_mux (
    .clk      (clk),
    .reset_n  (reset_n),
    .active   (|eng_en),
    .sel      (cur_layer),
    .eng_addr (eng_addr),
    .eng_we   (eng_we),
    .eng_out  (eng_out),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata)
  );

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer: behavioural engines end 50 cycles after enable,
// expected state-change events and memory-port values are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_fc_layer_sequencer;

  localparam int NL        = 3;
  localparam int ENG_DELAY = 50;

  typedef struct packed {
    logic [8:0] snap;
    int         delta;
  } ev_t;

  typedef struct packed {
    int          at;
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } mem_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [16*NL-1:0] eng_addr;
  logic [NL-1:0]  eng_we;
  logic [16*NL-1:0] eng_out;
  logic [NL-1:0]  eng_end;
  logic [NL-1:0]  eng_en;
  logic [15:0]    mem_addr;
  logic           mem_we;
  logic [15:0]    mem_wdata;
  logic [2:0]     cur_layer;
  logic           busy;
  logic           done;
  logic           error;

  logic [NL-1:0]  end_q;
  logic [NL-1:0]  end_force;
  logic [NL-1:0]  hang;
  logic           eng_clr;
  int             eng_cnt [NL];
  int             cyc = 0;
  int             checks = 0;
  int             failures = 0;
  ev_t            ev_q[$];
  mem_t           mem_q[$];

  fc_layer_sequencer #(
    .NUM_LAYERS(NL),
    .TIMEOUT   (20'd100)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .eng_addr (eng_addr),
    .eng_we   (eng_we),
    .eng_out  (eng_out),
    .eng_end  (eng_end),
    .eng_en   (eng_en),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .cur_layer(cur_layer),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  assign eng_end = end_q | end_force;

  // Behavioural engines: sticky layer_end ENG_DELAY cycles after enable, cleared by reset or eng_clr.
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n || eng_clr) begin
      end_q = '0;
      for (int k = 0; k < NL; k++) eng_cnt[k] = 0;
    end else begin
      for (int k = 0; k < NL; k++) begin
        if (eng_en[k] && !end_q[k] && !hang[k]) begin
          eng_cnt[k] = eng_cnt[k] + 1;
          if (eng_cnt[k] == ENG_DELAY) end_q[k] = 1'b1;
        end
      end
    end
  end

  function automatic logic [8:0] mk(input logic [2:0] en, input logic b, input logic d,
                                    input logic e, input logic [2:0] cl);
    return {en, b, d, e, cl};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic pushEv(input logic [8:0] snap, input int delta);
    ev_t e;
    e.snap  = snap;
    e.delta = delta;
    ev_q.push_back(e);
  endtask

  task automatic pushMem(input logic [15:0] addr, input logic we, input logic [15:0] wdata);
    mem_t m;
    m.at    = cyc + 1;
    m.addr  = addr;
    m.we    = we;
    m.wdata = wdata;
    mem_q.push_back(m);
  endtask

  // Expected snapshot changes for one pass from layer 0 up to lastLayer.
  task automatic queueRun(input bit fromIdle, input int lastLayer, input bit timeoutLast);
    if (!fromIdle) pushEv(mk(3'b000, 1'b0, 1'b0, 1'b0, 3'd0), -1);
    for (int k = 0; k <= lastLayer; k++) begin
      pushEv(mk(3'(1 << k), 1'b1, 1'b0, 1'b0, 3'(k)), (fromIdle && k == 0) ? -1 : 1);
      if (k < lastLayer) begin
        pushEv(mk(3'b000, 1'b1, 1'b0, 1'b0, 3'(k)), ENG_DELAY);
        pushEv(mk(3'b000, 1'b0, 1'b0, 1'b0, 3'(k + 1)), 1);
      end else if (timeoutLast) begin
        pushEv(mk(3'b000, 1'b0, 1'b0, 1'b1, 3'(k)), 100);
      end else if (k == NL - 1) begin
        pushEv(mk(3'b000, 1'b1, 1'b0, 1'b0, 3'(k)), ENG_DELAY);
        pushEv(mk(3'b000, 1'b0, 1'b1, 1'b0, 3'(k)), 1);
      end
    end
  endtask

  task automatic applyStimulus(input int layer, input logic [15:0] addr, input logic we,
                               input logic [15:0] data);
    eng_addr = '0;
    eng_out  = '0;
    eng_we   = '0;
    eng_addr[16*layer +: 16] = addr;
    eng_out[16*layer +: 16]  = data;
    eng_we[layer]            = we;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clearEngines();
    eng_clr = 1'b1;
    repeat (2) @(negedge clk);
    eng_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((ev_q.size() != 0 || mem_q.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (ev_q.size() != 0 || mem_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout pending_events=%0d pending_mem=%0d expected=0",
               ev_q.size(), mem_q.size());
      ev_q.delete();
      mem_q.delete();
    end
  endtask

  // Monitor: any change of the control snapshot pops one expected event; mem entries fire by cycle.
  task automatic monitorLoop();
    logic [8:0] prev;
    logic [8:0] snap;
    int         last;
    ev_t        e;
    mem_t       m;
    prev = {eng_en, busy, done, error, cur_layer};
    last = cyc;
    forever begin
      @(negedge clk);
      snap = {eng_en, busy, done, error, cur_layer};
      if (snap !== prev) begin
        if (ev_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_event got=%0h expected=none at cycle %0d", snap, cyc);
        end else begin
          e = ev_q.pop_front();
          checkOutput("state_snapshot", 32'(snap), 32'(e.snap));
          if (e.delta >= 0) checkOutput("event_spacing", 32'(cyc - last), 32'(e.delta));
        end
        prev = snap;
        last = cyc;
      end
      if (mem_q.size() != 0 && cyc >= mem_q[0].at) begin
        m = mem_q.pop_front();
        checkOutput("mem_addr", 32'(mem_addr), 32'(m.addr));
        checkOutput("mem_we", 32'(mem_we), 32'(m.we));
        checkOutput("mem_wdata", 32'(mem_wdata), 32'(m.wdata));
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    eng_addr  = '0;
    eng_out   = '0;
    eng_we    = '0;
    end_force = '0;
    hang      = '0;
    eng_clr   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_snapshot", 32'({eng_en, busy, done, error, cur_layer}), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_mem_ctl", 32'({mem_we, mem_wdata}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    fork
      monitorLoop();
    join_none

    $display("[TB] full three-layer run with ignored start and foreign eng_end toggle");
    queueRun(1'b1, 2, 1'b0);
    pulseStart();
    repeat (5) @(negedge clk);
    pulseStart();
    repeat (3) @(negedge clk);
    end_force[2] = 1'b1;
    repeat (3) @(negedge clk);
    end_force[2] = 1'b0;
    repeat (47) @(negedge clk);
    applyStimulus(1, 16'd5, 1'b0, 16'h0000);
    pushMem(16'd205, 1'b0, 16'h0000);
    @(negedge clk);
    applyStimulus(1, 16'd1, 1'b1, 16'h0A0B);
    pushMem(16'd400, 1'b1, 16'h0A0B);
    @(negedge clk);
    applyStimulus(1, 16'd0, 1'b0, 16'h0000);
    pushMem(16'd200, 1'b0, 16'h0A0B);
    waitDrain(300);
    pushMem(16'd0, 1'b0, 16'h0A0B);
    waitDrain(5);

    $display("[TB] restart with stale layer_end");
    pushEv(mk(3'b000, 1'b0, 1'b0, 1'b0, 3'd0), -1);
    pushEv(mk(3'b000, 1'b0, 1'b0, 1'b1, 3'd0), 1);
    pulseStart();
    waitDrain(20);
    repeat (5) @(negedge clk);

    $display("[TB] layer 2 timeout");
    clearEngines();
    hang = 3'b100;
    queueRun(1'b0, 2, 1'b1);
    pulseStart();
    waitDrain(400);
    hang = '0;

    $display("[TB] reset during layer 1");
    clearEngines();
    queueRun(1'b0, 1, 1'b0);
    pulseStart();
    repeat (69) @(negedge clk);
    waitDrain(5);
    pushEv(mk(3'b000, 1'b0, 1'b0, 1'b0, 3'd0), -1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_en", 32'(eng_en), 32'd0);
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    checkOutput("async_reset_layer", 32'(cur_layer), 32'd0);
    checkOutput("async_reset_mem", 32'(mem_addr), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    queueRun(1'b1, 2, 1'b0);
    pulseStart();
    waitDrain(400);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
